// File: rtl/pic_pkg.sv
// Shared definitions for the LCD picture path: panel geometry, RGB565 colours
// and the UART receiver state encoding.
package pic_pkg;

    localparam int unsigned LCD_WIDTH   = 240;
    localparam int unsigned LCD_HEIGHT  = 320;
    localparam int unsigned FRAME_BYTES = LCD_WIDTH * LCD_HEIGHT * 2;

    // RGB565 colour constants
    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;

    // One-hot receiver states
    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StStart = 4'b0010,
        StData  = 4'b0100,
        StStop  = 4'b1000
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchronizer, start/data/stop FSM and baud/bit counters.
// rx_valid and rx_ferr are combinational one-cycle pulses in the stop-bit
// sample cycle; rx_byte holds the assembled byte.
module uart_rx_core
    import pic_pkg::*;
#(
    parameter int unsigned BIT_CYC = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int unsigned HALF  = BIT_CYC / 2;
    localparam int unsigned CNT_W = $clog2(BIT_CYC);

    logic             rx_meta, rx_sync, rx_prev;
    // live_q: rx_meta holds a real line sample; armed_q: line seen high since reset
    logic             live_q, armed_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;

    // State, counters, synchronizer and edge-detect registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            live_q     <= 1'b0;
            armed_q    <= 1'b0;
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            live_q     <= 1'b1;
            // A line low at reset release must rise before a start can count
            armed_q    <= armed_q | (live_q & rx_meta);
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (armed_q && rx_prev && !rx_sync) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_cnt_q == CNT_W'(HALF - 1)) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = rx_sync ? StIdle : StData;
                end
            end
            StData: begin
                if (baud_cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    baud_cnt_d         = '0;
                    shreg_d[bit_idx_q] = rx_sync;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    rx_valid   = rx_sync;
                    rx_ferr    = ~rx_sync;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_byte = shreg_q;

endmodule

// File: rtl/uart_pic_loader.sv
// Picture loader top: forwards each received UART byte into the picture FIFO,
// flags overflow and framing errors, and tracks the frame byte position.
module uart_pic_loader #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FRAME_BYTES = pic_pkg::FRAME_BYTES
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rx,
    input  logic        fifo_full,
    input  logic        frame_clr,
    output logic        fifo_wrEn,
    output logic [7:0]  fifo_wdata,
    output logic [17:0] byte_cnt,
    output logic        frame_done,
    output logic        frame_err,
    output logic        ovf
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr;
    logic        wr_d, ovf_d, done_d, last_byte;
    logic [7:0]  wdata_d;
    logic [17:0] cnt_d;

    uart_rx_core #(
        .BIT_CYC (BIT_CYC)
    ) u_core (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    // FIFO write / overflow / frame position next-state
    always_comb begin
        last_byte = (byte_cnt == 18'(FRAME_BYTES - 1));
        wr_d      = rx_valid & ~fifo_full;
        ovf_d     = rx_valid & fifo_full;
        wdata_d   = wr_d ? rx_byte : fifo_wdata;
        done_d    = rx_valid & last_byte;
        cnt_d     = byte_cnt;
        // Dropped bytes still advance the count so alignment follows the sender
        if (rx_valid) begin
            cnt_d = last_byte ? '0 : byte_cnt + 18'd1;
        end
        if (frame_clr) begin
            cnt_d = '0;
        end
    end

    // Registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fifo_wrEn  <= 1'b0;
            fifo_wdata <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            fifo_wrEn  <= wr_d;
            fifo_wdata <= wdata_d;
            byte_cnt   <= cnt_d;
            frame_done <= done_d;
            frame_err  <= rx_ferr;
            ovf        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_pic_loader.sv
// Directed bench for uart_pic_loader with a 4-byte frame at 50 MHz / 115200.
module tb_uart_pic_loader;

    localparam int BIT_CYC = 434;
    localparam int LAT     = 4126;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rx = 1'b1;
    logic        fifo_full = 1'b0;
    logic        frame_clr = 1'b0;
    logic        fifo_wrEn;
    logic [7:0]  fifo_wdata;
    logic [17:0] byte_cnt;
    logic        frame_done, frame_err, ovf;

    uart_pic_loader #(
        .CLK_FREQ    (50_000_000),
        .BAUD        (115200),
        .FRAME_BYTES (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx         (rx),
        .fifo_full  (fifo_full),
        .frame_clr  (frame_clr),
        .fifo_wrEn  (fifo_wrEn),
        .fifo_wdata (fifo_wdata),
        .byte_cnt   (byte_cnt),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .ovf        (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge
    int         n_wr = 0, n_ovf = 0, n_ferr = 0, n_done = 0, n_done_al = 0;
    int         last_wr_cyc = 0;
    logic [7:0] last_wdata = 8'h00;
    always @(negedge sys_clk) begin
        if (fifo_wrEn) begin
            n_wr        <= n_wr + 1;
            last_wdata  <= fifo_wdata;
            last_wr_cyc <= cyc;
        end
        if (ovf)        n_ovf  <= n_ovf + 1;
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (frame_done) n_done <= n_done + 1;
        if (frame_done && (fifo_wrEn || ovf)) n_done_al <= n_done_al + 1;
    end

    int n_vec = 0;
    int n_miss = 0;
    int s_wr, s_ovf, s_ferr, s_done, s_al;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_wr = n_wr; s_ovf = n_ovf; s_ferr = n_ferr; s_done = n_done; s_al = n_done_al;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, output int t0);
        @(posedge sys_clk); #1 rx = 1'b0;
        t0 = cyc;
        for (int b = 0; b < 8; b++) begin
            repeat (BIT_CYC) @(posedge sys_clk);
            #1 rx = d[b];
        end
        repeat (BIT_CYC) @(posedge sys_clk);
        #1 rx = stop;
        repeat (BIT_CYC) @(posedge sys_clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       clr;
        int         wr;
        int         ov;
        int         fe;
        int         dn;
        int         cnt;
    } vec_t;

    vec_t vecs[9];
    int   t0, lat;

    initial begin
        //            data   stop  full  clr   wr ov fe dn cnt
        vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 2};
        vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0, 3};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 1};
        vecs[5] = '{8'h02, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 2};
        vecs[6] = '{8'h03, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 3};
        vecs[7] = '{8'h04, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 0};
        vecs[8] = '{8'h05, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1};

        // Reset values
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst wrEn", fifo_wrEn, 0);
        check("rst wdata", fifo_wdata, 0);
        check("rst byte_cnt", byte_cnt, 0);
        check("rst frame_done", frame_done, 0);
        check("rst frame_err", frame_err, 0);
        check("rst ovf", ovf, 0);
        #1 sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk);

        // First byte: data and latency from the falling edge
        snap();
        send_byte(8'hA5, 1'b1, t0);
        check("A5 writes", n_wr - s_wr, 1);
        check("A5 data", last_wdata, 8'hA5);
        check("A5 byte_cnt", byte_cnt, 1);
        lat = last_wr_cyc - t0;
        n_vec++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            n_miss++;
            $display("FAIL A5 latency: got %0d cycles, expected %0d +/-1", lat, LAT);
        end

        // Table of single-byte transactions
        for (int i = 0; i < 9; i++) begin
            snap();
            if (vecs[i].clr) begin
                @(posedge sys_clk); #1 frame_clr = 1'b1;
                @(posedge sys_clk); #1 frame_clr = 1'b0;
            end
            fifo_full = vecs[i].full;
            send_byte(vecs[i].data, vecs[i].stop, t0);
            fifo_full = 1'b0;
            check($sformatf("v%0d writes", i), n_wr - s_wr, vecs[i].wr);
            check($sformatf("v%0d ovf", i), n_ovf - s_ovf, vecs[i].ov);
            check($sformatf("v%0d frame_err", i), n_ferr - s_ferr, vecs[i].fe);
            check($sformatf("v%0d frame_done", i), n_done - s_done, vecs[i].dn);
            check($sformatf("v%0d done aligned", i), n_done_al - s_al, vecs[i].dn);
            check($sformatf("v%0d byte_cnt", i), byte_cnt, vecs[i].cnt);
            if (vecs[i].wr != 0)
                check($sformatf("v%0d data", i), last_wdata, vecs[i].data);
        end

        // Short low glitch on an idle line is a false start
        snap();
        @(posedge sys_clk); #1 rx = 1'b0;
        repeat (100) @(posedge sys_clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge sys_clk);
        @(negedge sys_clk);
        check("glitch writes", n_wr - s_wr, 0);
        check("glitch frame_err", n_ferr - s_ferr, 0);
        check("glitch idle", dut.u_core.state_q, pic_pkg::StIdle);
        check("glitch byte_cnt", byte_cnt, 1);

        // Reset mid-DATA with the line still low on release
        snap();
        @(posedge sys_clk); #1 rx = 1'b0;
        repeat (4 * BIT_CYC) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (2 * BIT_CYC) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst-low no start", dut.u_core.state_q, pic_pkg::StIdle);
        #1 rx = 1'b1;
        repeat (12 * BIT_CYC) @(posedge sys_clk);
        @(negedge sys_clk);
        check("abort writes", n_wr - s_wr, 0);
        check("abort frame_err", n_ferr - s_ferr, 0);
        check("abort byte_cnt", byte_cnt, 0);
        snap();
        send_byte(8'h81, 1'b1, t0);
        check("81 writes", n_wr - s_wr, 1);
        check("81 data", last_wdata, 8'h81);
        check("81 byte_cnt", byte_cnt, 1);

        // frame_clr held across the write cycle
        snap();
        fork
            send_byte(8'h7E, 1'b1, t0);
            begin
                @(posedge sys_clk);
                repeat (LAT - 2) @(posedge sys_clk);
                #1 frame_clr = 1'b1;
                repeat (3) @(posedge sys_clk);
                #1 frame_clr = 1'b0;
            end
        join
        check("clr writes", n_wr - s_wr, 1);
        check("clr data", last_wdata, 8'h7E);
        check("clr byte_cnt", byte_cnt, 0);
        check("clr frame_done", n_done - s_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
